// File: rtl/lbist_pkg.sv
// Shared types and constants for the multi-CUT LBIST sequencer.
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        COMP,
        DONE
    } lbist_mc_state_e;

    localparam logic LBIST_MODE_RUN_ALL      = 1'b0;
    localparam logic LBIST_MODE_STOP_ON_FAIL = 1'b1;

endpackage

// File: rtl/lbist_chan_tracker.sv
// Per-CUT channel bookkeeping: seed/hash-count handshake flags and the
// captured MISR signature for the seed currently in flight.
module lbist_chan_tracker #(
    parameter int SIGNATURE_BITS = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_active,
    input  logic                      run_active,
    input  logic                      lfsr_resp_rdy,
    input  logic                      misr_req_rdy,
    input  logic                      misr_resp_val,
    input  logic [SIGNATURE_BITS-1:0] misr_resp_msg,
    output logic                      lfsr_resp_val,
    output logic                      misr_req_val,
    output logic                      misr_resp_rdy,
    output logic                      load_done,
    output logic                      sig_valid,
    output logic [SIGNATURE_BITS-1:0] sig
);

    logic                      lfsr_done_reg;
    logic                      misr_done_reg;
    logic                      sig_valid_reg;
    logic [SIGNATURE_BITS-1:0] sig_reg;
    logic                      lfsr_fire;
    logic                      misr_fire;
    logic                      sig_fire;

    assign lfsr_resp_val = load_active && !lfsr_done_reg;
    assign misr_req_val  = load_active && !misr_done_reg;
    assign misr_resp_rdy = run_active && !sig_valid_reg;

    assign lfsr_fire = lfsr_resp_val && lfsr_resp_rdy;
    assign misr_fire = misr_req_val && misr_req_rdy;
    assign sig_fire  = misr_resp_val && misr_resp_rdy;

    // Include this cycle's fires so the FSM can leave LOAD/RUN without a bubble.
    assign load_done = (lfsr_done_reg || lfsr_fire) && (misr_done_reg || misr_fire);
    assign sig_valid = sig_valid_reg || sig_fire;
    assign sig       = sig_reg;

    // Flags self-clear whenever the owning state is left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_done_reg <= 1'b0;
            misr_done_reg <= 1'b0;
            sig_valid_reg <= 1'b0;
            sig_reg       <= '0;
        end else begin
            lfsr_done_reg <= load_active && (lfsr_done_reg || lfsr_fire);
            misr_done_reg <= load_active && (misr_done_reg || misr_fire);
            sig_valid_reg <= run_active && (sig_valid_reg || sig_fire);
            if (sig_fire) begin
                sig_reg <= misr_resp_msg;
            end
        end
    end

endmodule

// File: rtl/lbist_controller_mc.sv
// Multi-CUT LBIST sequencer: loads each seed into all CUTs, collects their
// MISR signatures and records per-seed/per-CUT pass bits against golden values.
module lbist_controller_mc
    import lbist_pkg::*;
#(
    parameter int SEED_BITS           = 32,
    parameter int SIGNATURE_BITS      = 32,
    parameter int NUM_SEEDS           = 8,
    parameter int NUM_CUTS            = 2,
    parameter int NUM_HASHES          = 8,
    parameter int MAX_OUTPUTS_TO_HASH = 32,
    parameter int TIMEOUT_CYCLES      = 1024,
    parameter logic [NUM_SEEDS-1:0][SEED_BITS-1:0] LFSR_SEEDS = '0,
    parameter logic [NUM_SEEDS-1:0][NUM_CUTS-1:0][SIGNATURE_BITS-1:0] SIGNATURES = '0,
    localparam int MISR_MSG_BITS = $clog2(MAX_OUTPUTS_TO_HASH)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               lbist_req_val,
    output logic                               lbist_req_rdy,
    input  logic                               lbist_req_msg,
    output logic                               lbist_resp_val,
    input  logic                               lbist_resp_rdy,
    output logic [NUM_SEEDS*NUM_CUTS:0]        lbist_resp_msg,
    output logic [NUM_CUTS-1:0]                lfsr_resp_val,
    input  logic [NUM_CUTS-1:0]                lfsr_resp_rdy,
    output logic [SEED_BITS-1:0]               lfsr_resp_msg,
    output logic [NUM_CUTS-1:0]                misr_req_val,
    input  logic [NUM_CUTS-1:0]                misr_req_rdy,
    output logic [MISR_MSG_BITS:0]             misr_req_msg,
    input  logic [NUM_CUTS-1:0]                misr_resp_val,
    output logic [NUM_CUTS-1:0]                misr_resp_rdy,
    input  logic [NUM_CUTS*SIGNATURE_BITS-1:0] misr_resp_msg,
    output logic                               lfsr_cut_reset
);

    localparam int SEED_IDX_W = $clog2(NUM_SEEDS) + 1;
    localparam int TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam int PASS_W     = NUM_SEEDS * NUM_CUTS;
    localparam logic [SEED_IDX_W-1:0] LAST_SEED = SEED_IDX_W'(NUM_SEEDS - 1);
    localparam logic [TIMER_W-1:0]    LAST_TICK = TIMER_W'(TIMEOUT_CYCLES - 1);

    lbist_mc_state_e            state_reg, state_next;
    logic [SEED_IDX_W-1:0]      seed_idx_reg, seed_idx_next;
    logic [TIMER_W-1:0]         timer_reg, timer_next;
    logic [PASS_W-1:0]          pass_reg, pass_next;
    logic                       aborted_reg, aborted_next;
    logic                       mode_reg, mode_next;
    logic                       out_en_reg;

    logic                       load_active;
    logic                       run_active;
    logic [NUM_CUTS-1:0]        load_done_vec;
    logic [NUM_CUTS-1:0]        sig_valid_vec;
    logic [NUM_CUTS-1:0]        match_vec;
    logic [NUM_CUTS-1:0][SIGNATURE_BITS-1:0] sig_vec;
    logic [NUM_CUTS-1:0][SIGNATURE_BITS-1:0] golden_sel;
    logic [SEED_BITS-1:0]       seed_sel;

    assign load_active = (state_reg == LOAD);
    assign run_active  = (state_reg == RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CUTS; gi++) begin : g_chan
            lbist_chan_tracker #(
                .SIGNATURE_BITS (SIGNATURE_BITS)
            ) u_tracker (
                .clk           (clk),
                .reset_n       (reset_n),
                .load_active   (load_active),
                .run_active    (run_active),
                .lfsr_resp_rdy (lfsr_resp_rdy[gi]),
                .misr_req_rdy  (misr_req_rdy[gi]),
                .misr_resp_val (misr_resp_val[gi]),
                .misr_resp_msg (misr_resp_msg[gi*SIGNATURE_BITS +: SIGNATURE_BITS]),
                .lfsr_resp_val (lfsr_resp_val[gi]),
                .misr_req_val  (misr_req_val[gi]),
                .misr_resp_rdy (misr_resp_rdy[gi]),
                .load_done     (load_done_vec[gi]),
                .sig_valid     (sig_valid_vec[gi]),
                .sig           (sig_vec[gi])
            );
            assign match_vec[gi] = (sig_vec[gi] == golden_sel[gi]);
        end
    endgenerate

    // Table lookup as a compare-mux so the index width never has to match the table depth.
    always_comb begin
        seed_sel   = '0;
        golden_sel = '0;
        for (int s = 0; s < NUM_SEEDS; s++) begin
            if (seed_idx_reg == SEED_IDX_W'(s)) begin
                seed_sel   = LFSR_SEEDS[s];
                golden_sel = SIGNATURES[s];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            seed_idx_reg <= '0;
            timer_reg    <= '0;
            pass_reg     <= '0;
            aborted_reg  <= 1'b0;
            mode_reg     <= LBIST_MODE_RUN_ALL;
            out_en_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            seed_idx_reg <= seed_idx_next;
            timer_reg    <= timer_next;
            pass_reg     <= pass_next;
            aborted_reg  <= aborted_next;
            mode_reg     <= mode_next;
            out_en_reg   <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        seed_idx_next = seed_idx_reg;
        timer_next    = timer_reg;
        pass_next     = pass_reg;
        aborted_next  = aborted_reg;
        mode_next     = mode_reg;
        case (state_reg)
            IDLE: begin
                if (lbist_req_val && lbist_req_rdy) begin
                    mode_next     = lbist_req_msg;
                    pass_next     = '0;
                    aborted_next  = 1'b0;
                    seed_idx_next = '0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                if (&load_done_vec) begin
                    timer_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                timer_next = timer_reg + TIMER_W'(1);
                if (&sig_valid_vec) begin
                    state_next = COMP;
                end else if (timer_reg == LAST_TICK) begin
                    aborted_next = 1'b1;
                    state_next   = DONE;
                end
            end
            COMP: begin
                for (int s = 0; s < NUM_SEEDS; s++) begin
                    for (int c = 0; c < NUM_CUTS; c++) begin
                        if (seed_idx_reg == SEED_IDX_W'(s)) begin
                            pass_next[s*NUM_CUTS + c] = match_vec[c];
                        end
                    end
                end
                if (seed_idx_reg == LAST_SEED) begin
                    state_next = DONE;
                end else if ((mode_reg == LBIST_MODE_STOP_ON_FAIL) && !(&match_vec)) begin
                    aborted_next = 1'b1;
                    state_next   = DONE;
                end else begin
                    seed_idx_next = seed_idx_reg + SEED_IDX_W'(1);
                    state_next    = LOAD;
                end
            end
            DONE: begin
                if (lbist_resp_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // out_en_reg keeps req_rdy low while reset is held and releases it one cycle after.
    assign lbist_req_rdy  = (state_reg == IDLE) && out_en_reg;
    assign lbist_resp_val = (state_reg == DONE);
    assign lbist_resp_msg = {aborted_reg, pass_reg};
    assign lfsr_resp_msg  = load_active ? seed_sel : '0;
    assign misr_req_msg   = (MISR_MSG_BITS + 1)'(NUM_HASHES);
    assign lfsr_cut_reset = (state_reg == COMP);

endmodule
